fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer sitting directly upstream of the PC register.
- Drives ld_pc/pcmux to advance or redirect PC.
- Issues the memory read at the current PC and captures the returned word as the IR.
- Hands the IR to the execute stage over a valid/ready handshake, then waits for execute completion before the next fetch.

Parameters:
- MEM_TIMEOUT, 16, max cycles F_WAIT waits for mem_ready before declaring a fetch error; legal range ≥ 2.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  start/continue fetching; sampled only in IDLE and at instruction boundaries
- pc_in  input  16  current PC value
- ld_pc  output  1  PC load enable, combinational from state
- pcmux  output  2  PC source select: 00 = PC+1, 01 = BUS, 10 = ADDER; combinational
- mem_addr  output  16  registered read address
- mem_rd  output  1  registered read request
- mem_rdata  input  16  read data, valid when mem_ready = 1
- mem_ready  input  1  read completion strobe
- ir  output  16  registered instruction word
- ir_valid  output  1  IR offered to execute stage
- ir_ready  input  1  execute stage accepts IR
- exec_done  input  1  execute stage finished current instruction, 1-cycle pulse
- redirect  input  1  with exec_done: load PC from a non-sequential source
- redirect_sel  input  1  0 = BUS (pcmux 01), 1 = ADDER (pcmux 10)
- fetch_err  output  1  sticky memory-timeout flag
- instr_count  output  CNT_W  count of IR handshakes completed

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; mem_addr = 0, mem_rd = 0, ir = 0, ir_valid = 0, fetch_err = 0, instr_count = 0, wait counter = 0; ld_pc = 0, pcmux = 00.
- Reset mid-operation aborts any outstanding read; mem_rd drops immediately.
- States: IDLE, F_ADDR, F_WAIT, ISSUE, EXEC, ERR.
- IDLE:
  - ld_pc = 0.
  - run = 1 → F_ADDR.
- F_ADDR (exactly 1 cycle):
  - ld_pc = 1, pcmux = 00, so PC increments at end of cycle.
  - mem_addr <= pc_in (pre-increment value); mem_rd <= 1; wait counter <= 0.
  - → F_WAIT.
- F_WAIT:
  - mem_rd held 1, mem_addr held.
  - mem_ready = 1: ir <= mem_rdata, mem_rd <= 0, ir_valid <= 1 → ISSUE.
  - Otherwise, counter == MEM_TIMEOUT-1: mem_rd <= 0, fetch_err <= 1 → ERR.
  - Otherwise, counter increments.
  - mem_ready on the timeout cycle: data is accepted, no error.
- ISSUE:
  - ir_valid = 1; ir stable until accepted.
  - ir_valid & ir_ready: ir_valid <= 0, instr_count <= instr_count+1 (wraps modulo 2^CNT_W) → EXEC.
  - exec_done ignored in this state.
- EXEC: wait for exec_done.
  - On exec_done with redirect = 1: ld_pc = 1 that cycle, pcmux = redirect_sel ? 10 : 01.
  - On exec_done with redirect = 0: ld_pc = 0.
  - Next state: run = 1 → F_ADDR, else → IDLE.
  - redirect without exec_done is ignored.
- ERR:
  - All requests 0, ld_pc = 0, fetch_err = 1.
  - Leaves only on reset.
- ld_pc is asserted only in F_ADDR and on an EXEC redirect cycle.
- pcmux = 00 whenever ld_pc = 0; pcmux is never 11.
- Latency with zero-wait memory (mem_ready in the first F_WAIT cycle):
  - run sampled in IDLE at cycle 0 → ld_pc at cycle 1 → mem_rd at cycle 2 → ir_valid at cycle 3.
  - exec_done at cycle N → F_ADDR at N+1.
- Deasserting run mid-instruction has no effect until the EXEC exit decision.

Test Plan:
- Reset, pc_in = 3000h, run = 1, mem_ready same cycle as mem_rd, mem_rdata = 1234h → ld_pc = 1/pcmux = 00 at cycle 1, mem_addr = 3000h, ir = 1234h with ir_valid at cycle 3.
- mem_ready delayed 5 cycles, ir_ready held low 4 cycles → mem_rd high exactly 6 cycles; ir stable and ir_valid held; instr_count = 1 only after the handshake.
- EXEC exit with exec_done + redirect, redirect_sel = 1 → one cycle ld_pc = 1, pcmux = 10; next F_ADDR fetches from new pc_in = 3050h. Repeat with redirect_sel = 0 → pcmux = 01.
- mem_ready never asserted, MEM_TIMEOUT = 16 → fetch_err rises 16 cycles after mem_rd; mem_rd = 0; ld_pc stays 0 until reset clears fetch_err.
- run dropped during ISSUE → current instruction completes; after exec_done, state returns to IDLE with no further ld_pc. Async reset asserted in F_WAIT → mem_rd and ir_valid go 0 immediately.
- 65537 back-to-back instructions with CNT_W = 16 → instr_count wraps to 1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steps the PC, reads the instruction word at the current PC,
// hands it to execute over valid/ready, and waits for execute completion before the next fetch.
module fetch_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [15:0]      pc_in,
   output logic             ld_pc,
   output logic [1:0]       pcmux,
   output logic [15:0]      mem_addr,
   output logic             mem_rd,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [15:0]      ir,
   output logic             ir_valid,
   input  logic             ir_ready,
   input  logic             exec_done,
   input  logic             redirect,
   input  logic             redirect_sel,
   output logic             fetch_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] MUX_INC   = 2'b00;
   localparam logic [1:0] MUX_BUS   = 2'b01;
   localparam logic [1:0] MUX_ADDER = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      F_ADDR,
      F_WAIT,
      ISSUE,
      EXEC,
      ERR
   } state_t;

   state_t state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ld_pc/pcmux are combinational so the PC register steps in the same cycle the decision is made.
   always_comb begin
      state_nxt = state;
      ld_pc     = 1'b0;
      pcmux     = MUX_INC;
      case (state)
         IDLE: begin
            if (run) state_nxt = F_ADDR;
         end
         F_ADDR: begin
            ld_pc     = 1'b1;
            pcmux     = MUX_INC;
            state_nxt = F_WAIT;
         end
         F_WAIT: begin
            if (mem_ready)                  state_nxt = ISSUE;
            else if (wait_cnt == WAIT_LAST) state_nxt = ERR;
         end
         ISSUE: begin
            if (ir_ready) state_nxt = EXEC;
         end
         EXEC: begin
            if (exec_done) begin
               if (redirect) begin
                  ld_pc = 1'b1;
                  pcmux = redirect_sel ? MUX_ADDER : MUX_BUS;
               end
               state_nxt = run ? F_ADDR : IDLE;
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A ready strobe on the final wait cycle wins over the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         ir          <= '0;
         ir_valid    <= 1'b0;
         fetch_err   <= 1'b0;
         instr_count <= '0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            F_ADDR: begin
               mem_addr <= pc_in;
               mem_rd   <= 1'b1;
               wait_cnt <= '0;
            end
            F_WAIT: begin
               if (mem_ready) begin
                  ir       <= mem_rdata;
                  mem_rd   <= 1'b0;
                  ir_valid <= 1'b1;
               end else if (wait_cnt == WAIT_LAST) begin
                  mem_rd    <= 1'b0;
                  fetch_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ISSUE: begin
               if (ir_ready) begin
                  ir_valid    <= 1'b0;
                  instr_count <= instr_count + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: the bench plays PC register and memory, and predicts
// fetch addresses, instruction words and handshake counts from an instruction-level model.
module tb_fetch_ctrl;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             run;
   logic [15:0]      pc_in;
   logic             ld_pc;
   logic [1:0]       pcmux;
   logic [15:0]      mem_addr;
   logic             mem_rd;
   logic [15:0]      mem_rdata;
   logic             mem_ready;
   logic [15:0]      ir;
   logic             ir_valid;
   logic             ir_ready;
   logic             exec_done;
   logic             redirect;
   logic             redirect_sel;
   logic             fetch_err;
   logic [CNT_W-1:0] instr_count;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] pc;
   logic [15:0] bus_val;
   logic [15:0] adder_val;
   logic [15:0] mem_key;
   logic [15:0] model_pc;
   int          model_count;

   always #5 clk = ~clk;

   assign pc_in     = pc;
   // Memory contents are a keyed function of the address; garbage is returned while not ready.
   assign mem_rdata = mem_ready ? (mem_addr ^ mem_key) : ~(mem_addr ^ mem_key);

   fetch_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run), .pc_in(pc_in),
      .ld_pc(ld_pc), .pcmux(pcmux), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir(ir), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .exec_done(exec_done), .redirect(redirect),
      .redirect_sel(redirect_sel), .fetch_err(fetch_err), .instr_count(instr_count)
   );

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic mrdy, input logic irdy,
                                input logic done, input logic redir, input logic sel);
      run          = r;
      mem_ready    = mrdy;
      ir_ready     = irdy;
      exec_done    = done;
      redirect     = redir;
      redirect_sel = sel;
      #1;
   endtask

   // Advance one clock, updating the bench-owned PC register from ld_pc/pcmux.
   task automatic tick();
      logic [15:0] nxt;
      nxt = pc;
      if (ld_pc === 1'b1) begin
         case (pcmux)
            2'b00:   nxt = pc + 16'd1;
            2'b01:   nxt = bus_val;
            2'b10:   nxt = adder_val;
            default: nxt = 16'hxxxx;
         endcase
      end
      @(posedge clk);
      #1;
      pc = nxt;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, rbit(), rbit(), rbit(), rbit(), rbit());
         checkOutput("idle_ld_pc", 32'(ld_pc), 0);
         checkOutput("idle_pcmux", 32'(pcmux), 0);
         checkOutput("idle_mem_rd", 32'(mem_rd), 0);
         tick();
      end
   endtask

   // One complete instruction, entered with the DUT in its fetch-address cycle.
   task automatic do_instr(input int mem_dly, input int ir_dly, input int ex_dly,
                           input logic redir, input logic sel, input logic [15:0] target,
                           input logic run_next);
      logic [15:0] exp_word;
      bus_val   = sel ? ~target : target;
      adder_val = sel ? target : ~target;
      applyStimulus(rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("faddr_ld_pc", 32'(ld_pc), 1);
      checkOutput("faddr_pcmux", 32'(pcmux), 0);
      checkOutput("faddr_mem_rd", 32'(mem_rd), 0);
      tick();
      exp_word = model_pc ^ mem_key;
      for (int i = 0; i <= mem_dly; i++) begin
         applyStimulus(rbit(), (i == mem_dly), rbit(), rbit(), rbit(), rbit());
         checkOutput("wait_mem_rd", 32'(mem_rd), 1);
         checkOutput("wait_mem_addr", 32'(mem_addr), 32'(model_pc));
         checkOutput("wait_ld_pc", 32'(ld_pc), 0);
         checkOutput("wait_ir_valid", 32'(ir_valid), 0);
         checkOutput("wait_fetch_err", 32'(fetch_err), 0);
         tick();
      end
      for (int j = 0; j <= ir_dly; j++) begin
         applyStimulus(rbit(), 1'b0, (j == ir_dly), rbit(), rbit(), rbit());
         checkOutput("issue_ir_valid", 32'(ir_valid), 1);
         checkOutput("issue_ir", 32'(ir), 32'(exp_word));
         checkOutput("issue_mem_rd", 32'(mem_rd), 0);
         checkOutput("issue_ld_pc", 32'(ld_pc), 0);
         checkOutput("issue_count", 32'(instr_count), model_count % (1 << CNT_W));
         tick();
      end
      model_count++;
      for (int k = 0; k <= ex_dly; k++) begin
         logic last;
         last = (k == ex_dly);
         applyStimulus(last ? run_next : rbit(), 1'b0, rbit(), last, last ? redir : rbit(), sel);
         checkOutput("exec_ir_valid", 32'(ir_valid), 0);
         checkOutput("exec_count", 32'(instr_count), model_count % (1 << CNT_W));
         checkOutput("exec_ld_pc", 32'(ld_pc), 32'(last && redir));
         checkOutput("exec_pcmux", 32'(pcmux), (last && redir) ? (sel ? 2 : 1) : 0);
         tick();
      end
      model_pc = redir ? target : model_pc + 16'd1;
   endtask

   initial begin
      logic rn;
      reset   = 1'b1;
      pc      = 16'h0000;
      bus_val = '0;
      adder_val = '0;
      mem_key = 16'h2234;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("rst_ld_pc", 32'(ld_pc), 0);
      checkOutput("rst_pcmux", 32'(pcmux), 0);
      checkOutput("rst_mem_rd", 32'(mem_rd), 0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 0);
      checkOutput("rst_ir", 32'(ir), 0);
      checkOutput("rst_ir_valid", 32'(ir_valid), 0);
      checkOutput("rst_fetch_err", 32'(fetch_err), 0);
      checkOutput("rst_count", 32'(instr_count), 0);

      // Zero-wait first fetch from 3000h returns 1234h.
      pc = 16'h3000;
      model_pc = 16'h3000;
      model_count = 0;
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_run_ld_pc", 32'(ld_pc), 0);
      tick();
      do_instr(0, 0, 1, 1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("first_ir", 32'(ir), 32'h1234);

      do_instr(5, 4, 2, 1'b1, 1'b1, 16'h3050, 1'b1);
      do_instr(0, 0, 0, 1'b1, 1'b0, 16'h3070, 1'b1);
      do_instr(MEM_TIMEOUT - 1, 1, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
      idle_cycles(3);

      mem_key = 16'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int n = 0; n < 24; n++) begin
         rn = ($urandom_range(0, 3) != 0) || (n == 23);
         do_instr($urandom_range(0, 3) == 0 ? $urandom_range(0, MEM_TIMEOUT - 1) : $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit(), 16'($urandom), rn);
         if (!rn) begin
            idle_cycles(2);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
         end
      end

      // Memory never answers: error after MEM_TIMEOUT wait cycles, then frozen.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("to_faddr_ld_pc", 32'(ld_pc), 1);
      tick();
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         applyStimulus(1'b1, 1'b0, rbit(), rbit(), rbit(), rbit());
         checkOutput("to_mem_rd", 32'(mem_rd), 1);
         checkOutput("to_fetch_err_low", 32'(fetch_err), 0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, rbit(), rbit(), rbit(), rbit(), rbit());
         checkOutput("err_fetch_err", 32'(fetch_err), 1);
         checkOutput("err_mem_rd", 32'(mem_rd), 0);
         checkOutput("err_ld_pc", 32'(ld_pc), 0);
         checkOutput("err_ir_valid", 32'(ir_valid), 0);
         tick();
      end
      reset = 1'b1;
      #1;
      checkOutput("err_rst_fetch_err", 32'(fetch_err), 0);
      reset = 1'b0;

      // Asynchronous reset while a read is outstanding.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_mem_rd", 32'(mem_rd), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_mem_rd", 32'(mem_rd), 0);
      checkOutput("async_rst_ir_valid", 32'(ir_valid), 0);
      reset = 1'b0;

      // Asynchronous reset while the IR is being offered.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_ir_valid", 32'(ir_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("issue_rst_ir_valid", 32'(ir_valid), 0);
      checkOutput("issue_rst_ir", 32'(ir), 0);
      reset = 1'b0;

      // Count wraps after 2^CNT_W + 1 handshakes.
      model_pc = pc;
      model_count = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int n = 0; n < (1 << CNT_W) + 1; n++) begin
         do_instr(0, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b1);
      end
      checkOutput("count_wrap", 32'(instr_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
